// File: rtl/rng_lfsr_pool_pkg.sv
// Shared constants and LFSR step function for the rng_lfsr_pool entropy source.
package rng_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_SHIFTS = 32;
  localparam int unsigned LFSR_MAX_W     = 64;

  // Fibonacci step on the low `width` bits: shift right, XOR-reduced taps enter at the top.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] poly,
                                                      input int unsigned           width);
    logic fb;
    fb = ^(state & poly);
    return (state >> 1) | (fb ? (LFSR_MAX_W'(1) << (width - 1)) : '0);
  endfunction

endpackage

// File: rtl/rng_lfsr_pool_core.sv
// LFSR state register with seed load, zero-seed substitution and lockup recovery.
module rng_lfsr_core
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] state_d_o,
  output logic             shift_o,
  output logic             recover_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] state_q;
  logic             is_zero;

  assign state_d_o = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(poly_i), WIDTH));
  assign is_zero   = (state_q == '0);
  assign recover_o = !load_i && is_zero;
  assign shift_o   = !load_i && !is_zero && adv_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEFAULT_SEED;
      lockup_o <= 1'b0;
    end else if (load_i) begin
      state_q  <= (seed_i == '0) ? DEFAULT_SEED : seed_i;
      lockup_o <= 1'b0;
    end else if (is_zero) begin
      state_q  <= DEFAULT_SEED;
      lockup_o <= 1'b1;
    end else if (adv_i) begin
      state_q  <= state_d_o;
    end
  end

endmodule

// File: rtl/rng_lfsr_pool.sv
// LFSR entropy pool: SHIFTS steps per emitted word behind a valid/ready holding register.
module rng_lfsr_pool
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned      SHIFTS       = DEFAULT_SHIFTS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             lockup_o
);

  localparam int unsigned      CNT_W    = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFTS - 1);

  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] state_d;
  logic             at_last, stall, adv, shift, recover, capture;

  // Freeze only on the word-completing step, so a pending word is never overwritten.
  assign at_last = (count_q == CNT_LAST);
  assign stall   = at_last && valid_o && !ready_i;
  assign adv     = en_i && !stall;
  assign capture = shift && at_last;

  rng_lfsr_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (adv),
    .load_i    (load_i),
    .seed_i    (seed_i),
    .poly_i    (poly_i),
    .state_d_o (state_d),
    .shift_o   (shift),
    .recover_o (recover),
    .lockup_o  (lockup_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i || recover) begin
      count_q <= '0;
    end else if (shift) begin
      count_q <= at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_o  <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b0;
    end else if (capture) begin
      word_o  <= state_d;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rng_lfsr_pool.sv
// Directed and scoreboard checks for rng_lfsr_pool (4-bit and 32-bit instances).
module tb_rng_lfsr_pool;
  import rng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, ready, valid, lockup;
  logic [3:0] seed, poly, word;

  logic        en_b, load_b, ready_b, valid_b, lockup_b;
  logic [31:0] seed_b, poly_b, word_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rng_lfsr_pool #(.WIDTH(4), .SHIFTS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .load_i(load), .seed_i(seed), .poly_i(poly),
    .word_o(word), .valid_o(valid), .ready_i(ready), .lockup_o(lockup)
  );

  rng_lfsr_pool #(.WIDTH(32), .SHIFTS(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .en_i(en_b), .load_i(load_b), .seed_i(seed_b), .poly_i(poly_b),
    .word_o(word_b), .valid_o(valid_b), .ready_i(ready_b), .lockup_o(lockup_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] s, input logic [3:0] p);
    load = 1'b1; seed = s; poly = p; en = 1'b0; ready = 1'b1;
    cyc();
    load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_tests++;
    if ({word, valid, lockup} !== 6'b0) begin
      n_fail++; $display("FAIL reset_in: got word=%h valid=%b lockup=%b want 0/0/0", word, valid, lockup);
    end
    rst_n = 1'b1;
    cyc(); cyc();
    n_tests++;
    if ({word, valid, lockup} !== 6'b0) begin
      n_fail++; $display("FAIL reset_out: got word=%h valid=%b lockup=%b want 0/0/0", word, valid, lockup);
    end
  endtask

  task automatic test_known_sequence();
    logic [3:0] exp_w;
    do_load(4'h1, 4'h3);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i % 4 == 0)) begin
        n_fail++; $display("FAIL known_valid c%0d: got %b want %b", i, valid, (i % 4 == 0));
      end
      if (i % 4 == 0) begin
        exp_w = (i == 4) ? 4'h9 : 4'h5;
        n_tests++;
        if (word !== exp_w) begin
          n_fail++; $display("FAIL known_word c%0d: got %h want %h", i, word, exp_w);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_load(4'h1, 4'h3);
    repeat (4) cyc();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_tests++;
      if (valid !== 1'b1 || word !== 4'h9) begin
        n_fail++; $display("FAIL bp_hold c%0d: got valid=%b word=%h want 1/9", i, valid, word);
      end
    end
    ready = 1'b1;
    cyc();
    n_tests++;
    if (valid !== 1'b1 || word !== 4'h5) begin
      n_fail++; $display("FAIL bp_release: got valid=%b word=%h want 1/5", valid, word);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i == 4) || (i == 4 && word !== 4'hF)) begin
        n_fail++; $display("FAIL bp_next c%0d: got valid=%b word=%h want %b/f", i, valid, word, (i == 4));
      end
    end
  endtask

  task automatic test_zero_seed();
    do_load(4'h0, 4'h3);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i % 4 == 0) || lockup !== 1'b0) begin
        n_fail++; $display("FAIL zseed_valid c%0d: got valid=%b lockup=%b want %b/0", i, valid, lockup, (i % 4 == 0));
      end
      if (i % 4 == 0) begin
        n_tests++;
        if (word !== ((i == 4) ? 4'h9 : 4'h5)) begin
          n_fail++; $display("FAIL zseed_word c%0d: got %h want %h", i, word, (i == 4) ? 4'h9 : 4'h5);
        end
      end
    end
  endtask

  task automatic test_lockup();
    do_load(4'h8, 4'h0);
    repeat (4) cyc();
    n_tests++;
    if (valid !== 1'b1 || word !== 4'h0 || lockup !== 1'b0) begin
      n_fail++; $display("FAIL lock_decay: got valid=%b word=%h lockup=%b want 1/0/0", valid, word, lockup);
    end
    cyc();
    n_tests++;
    if (lockup !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_flag: got lockup=%b valid=%b want 1/0", lockup, valid);
    end
    poly = 4'h3;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i == 4) || lockup !== 1'b1 || (i == 4 && word !== 4'h9)) begin
        n_fail++; $display("FAIL lock_recover c%0d: got valid=%b word=%h lockup=%b want %b/9/1", i, valid, word, lockup, (i == 4));
      end
    end
    do_load(4'h1, 4'h3);
    n_tests++;
    if (lockup !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_clear: got lockup=%b valid=%b want 0/0", lockup, valid);
    end
  endtask

  task automatic test_en_hold();
    do_load(4'h1, 4'h3);
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_tests++;
      if (valid !== 1'b0) begin
        n_fail++; $display("FAIL en_hold c%0d: got valid=%b want 0", i, valid);
      end
    end
    en = 1'b1;
    cyc(); cyc();
    n_tests++;
    if (valid !== 1'b1 || word !== 4'h9) begin
      n_fail++; $display("FAIL en_resume: got valid=%b word=%h want 1/9", valid, word);
    end
    en = 1'b0; ready = 1'b0;
    cyc();
    ready = 1'b1;
    cyc();
    n_tests++;
    if (valid !== 1'b0 || word !== 4'h9) begin
      n_fail++; $display("FAIL en_drain: got valid=%b word=%h want 0/9", valid, word);
    end
  endtask

  task automatic test_reset_mid_word();
    do_load(4'h1, 4'h3);
    repeat (4) cyc();
    ready = 1'b0;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({word, valid, lockup} !== 6'b0) begin
      n_fail++; $display("FAIL rst_async: got word=%h valid=%b lockup=%b want 0/0/0", word, valid, lockup);
    end
    en = 1'b0; ready = 1'b1;
    #2 rst_n = 1'b1;
    cyc();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i == 4) || (i == 4 && word !== 4'h9)) begin
        n_fail++; $display("FAIL rst_first c%0d: got valid=%b word=%h want %b/9", i, valid, word, (i == 4));
      end
    end
  endtask

  task automatic test_load_priority();
    do_load(4'h1, 4'h3);
    repeat (4) cyc();
    load = 1'b1; seed = 4'h2; ready = 1'b1; en = 1'b1;
    cyc();
    load = 1'b0;
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL ldprio_drop: got valid=%b want 0", valid);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tests++;
      if (valid !== (i == 4) || (i == 4 && word !== 4'hB)) begin
        n_fail++; $display("FAIL ldprio_restart c%0d: got valid=%b word=%h want %b/b", i, valid, word, (i == 4));
      end
    end
  endtask

  task automatic test_random32();
    logic [31:0] m_state, m_word;
    int unsigned m_count;
    logic        m_valid, stall, cap;
    int          dut_hs, mdl_hs;
    dut_hs = 0; mdl_hs = 0;
    load_b = 1'b1; seed_b = $urandom | 32'h1; poly_b = $urandom | 32'h1; en_b = 1'b0; ready_b = 1'b0;
    cyc();
    load_b = 1'b0;
    m_state = seed_b; m_count = 0; m_valid = 1'b0; m_word = '0;
    for (int i = 0; i < 1200; i++) begin
      en_b    = ($urandom_range(3) != 0);
      ready_b = 1'($urandom_range(1));
      if (i % 100 == 50) poly_b = $urandom | 32'h1;
      if (valid_b && ready_b) dut_hs++;
      if (m_valid && ready_b) mdl_hs++;
      stall = (m_count == 31) && m_valid && !ready_b;
      cap   = 1'b0;
      if (en_b && !stall) begin
        m_state = 32'(lfsr_next(64'(m_state), 64'(poly_b), 32));
        if (m_count == 31) begin
          m_count = 0; m_word = m_state; cap = 1'b1;
        end else begin
          m_count++;
        end
      end
      m_valid = cap ? 1'b1 : (ready_b ? 1'b0 : m_valid);
      cyc();
      n_tests++;
      if (valid_b !== m_valid || (m_valid && word_b !== m_word)) begin
        n_fail++; $display("FAIL rand c%0d: got valid=%b word=%h want %b/%h", i, valid_b, word_b, m_valid, m_word);
      end
    end
    n_tests++;
    if (dut_hs !== mdl_hs || mdl_hs == 0) begin
      n_fail++; $display("FAIL rand_count: got %0d handshakes want %0d (nonzero)", dut_hs, mdl_hs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; load = 1'b0; ready = 1'b0; seed = '0; poly = '0;
    en_b = 1'b0; load_b = 1'b0; ready_b = 1'b0; seed_b = '0; poly_b = '0;
    test_reset();
    test_known_sequence();
    test_backpressure();
    test_zero_seed();
    test_lockup();
    test_en_hold();
    test_reset_mid_word();
    test_load_priority();
    test_random32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
